seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Generalised serial pattern detector: matches a runtime-programmable pattern of 1..MAX_LEN bits
//  on a qualified bit stream. Supports overlapping/non-overlapping modes and gives a Mealy
//  (same-cycle) match flag plus a registered copy. Sits after serial front-ends as a framing/sync detector.
// PARAMETERS
//  MAX_LEN      8        maximum pattern length (>=2)
//  CNT_W        8        match counter width
//  DEFAULT_PAT  8'h09    pattern after reset (LSB-aligned; reset value = 1001)
//  DEFAULT_LEN  4        pattern length after reset (1..MAX_LEN)
//  LEN_W (localparam) = $clog2(MAX_LEN+1)
// PORTS
//  clk          in   1        rising-edge clock, sole clock domain
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        in_bit qualifier; bits are consumed only when high
//  in_bit       in   1        serial data bit
//  cfg_overlap  in   1        1 = overlapping matches allowed, 0 = window restarts after a match
//  cfg_load     in   1        1-cycle strobe: load cfg_pattern/cfg_len
//  cfg_pattern  in   MAX_LEN  pattern[len-1] = first bit received, pattern[0] = last bit received
//  cfg_len      in   LEN_W    pattern length
//  detect       out  1        Mealy match: high in the cycle the final pattern bit is presented
//  detect_q     out  1        detect registered (1-cycle latency)
//  cfg_err      out  1        registered 1-cycle pulse: rejected load
//  match_count  out  CNT_W    saturating match count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pattern=DEFAULT_PAT, len=DEFAULT_LEN, hist=0, fill=0, state=IDLE, detect_q=0, cfg_err=0,
//    match_count=0. detect is forced 0 while rst is high.
//  - hist: MAX_LEN-bit shift register; on each accepted bit, hist <= {hist[MAX_LEN-2:0], in_bit}.
//  - fill: valid-bit count, saturates at len-1. Control FSM:
//      IDLE  : fill=0; accepted bit -> FILL (or ARMED if len<=2, or match check if len=1)
//      FILL  : 0<fill<len-1; accepted bits increment fill; fill reaches len-1 -> ARMED
//      ARMED : fill=len-1; every accepted bit is compared
//  - detect = in_valid & ~rst & ~cfg_load & (fill==len-1) & ({hist[len-2:0],in_bit} == pattern[len-1:0]).
//    For len=1, compare in_bit with pattern[0] only.
//  - On detect: cfg_overlap=1 -> stay ARMED, hist shifts normally.
//    cfg_overlap=0 -> fill<=0, state<=IDLE (matching bit is not reused).
//  - in_valid=0: hist, fill and state hold; detect=0.
//  - cfg_load with 1<=cfg_len<=MAX_LEN: latch pattern/len, clear hist/fill/match_count, go IDLE.
//    An in_bit presented in the same cycle is discarded (detect=0).
//  - cfg_load with cfg_len=0 or cfg_len>MAX_LEN: config and state unchanged; cfg_err=1 next cycle.
//    An in_bit in that cycle is also discarded.
//  - cfg_overlap is sampled every cycle; a change takes effect on the next match.
//  - Async rst mid-sequence: partial window is lost; no detect until a full len bits arrive after release.
//  - Pattern bits above len-1 are ignored.
// CONFIGURATION
//  MATCH_COUNT_EN defined: match_count increments on each detect cycle, saturates at 2^CNT_W-1,
//    clears on reset and on accepted cfg_load.
//  MATCH_COUNT_EN undefined: no counter logic; match_count tied to 0.
// TESTING
//  1. Reset defaults, overlap=1, bits 1,0,0,1,0,0,1 -> detect on bits 4 and 7; detect_q one cycle later;
//     match_count=2.
//  2. Same stream, overlap=0 -> detect on bit 4 only (window restarts, bits 5-7 give fill 3);
//     match_count=1.
//  3. Load pattern=3'b110, len=3, overlap=1; stream 1,1,0,1,1,1,0 -> detect on bits 3 and 7.
//  4. Default pattern with idle gaps: 1,(v=0),0,0,(v=0)x2,1 -> single detect on the last valid bit;
//     detect=0 in all gap cycles.
//  5. cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulse each time; 1,0,0,1 still detected.
//  6. rst pulse after 1,0,0, then 1 -> no detect. With CNT_W=2 and 5 matches -> match_count=3 (saturated).

Source files
------------

// File: rtl/seq_pattern_detector_if.sv
// Bit-stream, configuration and result signals of the serial pattern detector.
interface seq_pattern_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in_bit;
    logic               cfg_overlap;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               detect;
    logic               detect_q;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in_valid, in_bit, cfg_overlap, cfg_load, cfg_pattern, cfg_len,
        input  detect, detect_q, cfg_err, match_count
    );

    modport slave (
        input  in_valid, in_bit, cfg_overlap, cfg_load, cfg_pattern, cfg_len,
        output detect, detect_q, cfg_err, match_count
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlap/restart modes).
// Optional saturating match counter is built only when MATCH_COUNT_EN is defined.
module seq_pattern_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'h09),
    parameter int                 DEFAULT_LEN = 4
) (
    input logic                   clk,
    input logic                   rst,
    seq_pattern_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    localparam logic [LEN_W-1:0]   LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] PAT_ZERO = {MAX_LEN{1'b0}};
    localparam logic [MAX_LEN-1:0] PAT_ONES = {MAX_LEN{1'b1}};

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [1:0]         r_state;
    logic               r_detect_q;
    logic               r_cfg_err;

    logic               w_cfg_ok;
    logic               w_accept;
    logic [LEN_W-1:0]   w_last;
    logic               w_armed;
    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_detect;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [1:0]         w_state_nxt;
    logic               w_unused_hist;

    assign w_cfg_ok = (bus.cfg_len != LEN_ZERO) && (bus.cfg_len <= LEN_MAX);
    assign w_accept = bus.in_valid & ~bus.cfg_load;
    assign w_last   = r_len - LEN_ONE;
    // A 1-bit pattern needs no history, so every accepted bit is a candidate.
    assign w_armed  = (r_state == ST_ARMED) | (r_len == LEN_ONE);
    assign w_cand   = {r_hist[MAX_LEN-2:0], bus.in_bit};
    assign w_mask   = ~(PAT_ONES << r_len);
    assign w_match  = ((w_cand ^ r_pattern) & w_mask) == PAT_ZERO;
    assign w_detect = w_accept & ~rst & w_armed & w_match;

    assign w_unused_hist = r_hist[MAX_LEN-1];

    // Next window fill level and control state for an accepted bit.
    always_comb begin
        w_fill_nxt  = r_fill;
        w_state_nxt = r_state;
        if (w_detect && !bus.cfg_overlap) begin
            w_fill_nxt = LEN_ZERO;
        end else if (r_fill != w_last) begin
            w_fill_nxt = r_fill + LEN_ONE;
        end else begin
            w_fill_nxt = r_fill;
        end
        if (w_fill_nxt == LEN_ZERO) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fill_nxt == w_last) begin
            w_state_nxt = ST_ARMED;
        end else begin
            w_state_nxt = ST_FILL;
        end
    end

    // Configuration, history shift register and control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= DEFAULT_PAT;
            r_len     <= LEN_W'(DEFAULT_LEN);
            r_hist    <= PAT_ZERO;
            r_fill    <= LEN_ZERO;
            r_state   <= ST_IDLE;
        end else if (bus.cfg_load) begin
            if (w_cfg_ok) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_hist    <= PAT_ZERO;
                r_fill    <= LEN_ZERO;
                r_state   <= ST_IDLE;
            end
        end else if (bus.in_valid) begin
            r_hist  <= w_cand;
            r_fill  <= w_fill_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Registered detect copy and rejected-load pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_detect_q <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_detect_q <= w_detect;
            r_cfg_err  <= bus.cfg_load & ~w_cfg_ok;
        end
    end

    assign bus.detect   = w_detect;
    assign bus.detect_q = r_detect_q;
    assign bus.cfg_err  = r_cfg_err;

`ifdef MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Saturating count of detect cycles, cleared by an accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_ZERO;
        end else if (bus.cfg_load && w_cfg_ok) begin
            r_count <= CNT_ZERO;
        end else if (w_detect && (r_count != CNT_ONES)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign bus.match_count = r_count;
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector with a per-cycle reference model.
module tb_seq_pattern_detector;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
`ifdef MATCH_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ovl_req = 1'b1;
    always #5 clk = ~clk;

    seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_pattern_detector #(
        .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .DEFAULT_PAT(8'h09), .DEFAULT_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bits seen since the last window restart plus current config.
    logic [31:0] m_bits = 32'd0;
    int          m_n = 0;
    logic [31:0] m_pat = 32'h09;
    int          m_len = 4;
    int          m_count = 0;
    logic        m_det_prev = 1'b0;
    logic        m_err_prev = 1'b0;
    logic [31:0] m_cand;
    logic [31:0] m_mask;
    logic        e_det;

    always @(negedge clk) begin
        m_mask = (32'd1 << m_len) - 32'd1;
        m_cand = (m_bits << 1) | {31'd0, bus.in_bit};
        e_det  = !rst && bus.in_valid && !bus.cfg_load && (m_n + 1 >= m_len)
                 && ((m_cand & m_mask) == (m_pat & m_mask));
        check("detect", {31'd0, bus.detect}, {31'd0, e_det});
        check("detect_q", {31'd0, bus.detect_q}, rst ? 32'd0 : {31'd0, m_det_prev});
        check("cfg_err", {31'd0, bus.cfg_err}, rst ? 32'd0 : {31'd0, m_err_prev});
        check("match_count", {30'd0, bus.match_count}, rst ? 32'd0 : 32'(m_count * CNT_ON));
        if (rst) begin
            m_bits = 32'd0; m_n = 0; m_pat = 32'h09; m_len = 4; m_count = 0;
            m_det_prev = 1'b0; m_err_prev = 1'b0;
        end else begin
            m_det_prev = e_det;
            m_err_prev = 1'b0;
            if (bus.cfg_load) begin
                if (bus.cfg_len >= 4'd1 && bus.cfg_len <= 4'd8) begin
                    m_pat = {24'd0, bus.cfg_pattern}; m_len = int'(bus.cfg_len);
                    m_bits = 32'd0; m_n = 0; m_count = 0;
                end else begin
                    m_err_prev = 1'b1;
                end
            end else if (bus.in_valid) begin
                m_bits = m_cand;
                if (m_n < 64) m_n++;
                if (e_det) begin
                    if (m_count < (1 << CNT_W) - 1) m_count++;
                    if (!bus.cfg_overlap) m_n = 0;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic ld, input logic [7:0] pat,
                         input logic [3:0] len, output logic det, output logic err);
        @(posedge clk); #1;
        bus.in_valid = v; bus.in_bit = b; bus.cfg_load = ld;
        bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ovl_req;
        @(negedge clk); #1;
        det = bus.detect;
        err = bus.cfg_err;
    endtask

    task automatic idle(output logic err);
        logic d;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, d, err);
    endtask

    task automatic stream(input logic [31:0] bits, input int n, output logic [31:0] vec);
        logic d, e;
        vec = 32'd0;
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, 8'h00, 4'd0, d, e);
            vec = {vec[30:0], d};
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic b, output logic det);
        logic e;
        drive(1'b1, b, 1'b1, pat, len, det, e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.cfg_load = 1'b0;
        @(negedge clk); #1;
        check("rst_detect_forced_low", {31'd0, bus.detect}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    endtask

    logic [31:0] vec;
    logic        d, e;
    logic [1:0]  gap_v [7] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};

    initial begin
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_detect_q", {31'd0, bus.detect_q}, 32'd0);
        check("reset_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
        check("reset_count", {30'd0, bus.match_count}, 32'd0);

        // Default pattern 1001, overlapping
        ovl_req = 1'b1;
        stream(32'b1001001, 7, vec);
        check("t1_detect_vec", vec, 32'b0001001);
        idle(e);
        check("t1_count", {30'd0, bus.match_count}, 32'(2 * CNT_ON));

        // Same stream, non-overlapping
        do_reset();
        ovl_req = 1'b0;
        stream(32'b1001001, 7, vec);
        check("t2_detect_vec", vec, 32'b0001000);
        idle(e);
        check("t2_count", {30'd0, bus.match_count}, 32'(CNT_ON));

        // Pattern 110, len 3; bit presented with the load is discarded
        ovl_req = 1'b1;
        load(8'b0000_0110, 4'd3, 1'b1, d);
        check("t3_load_detect", {31'd0, d}, 32'd0);
        stream(32'b1101110, 7, vec);
        check("t3_detect_vec", vec, 32'b0010001);

        // Idle gaps hold the window
        do_reset();
        vec = 32'd0;
        for (int i = 0; i < 7; i++) begin
            drive(gap_v[i][1], gap_v[i][0], 1'b0, 8'h00, 4'd0, d, e);
            vec = {vec[30:0], d};
        end
        check("t4_gap_vec", vec, 32'b0000001);

        // Rejected loads: cfg_err pulse, config and window kept
        do_reset();
        load(8'h55, 4'd0, 1'b0, d);
        idle(e);
        check("t5_err_len0", {31'd0, e}, 32'd1);
        idle(e);
        check("t5_err_one_cycle", {31'd0, e}, 32'd0);
        stream(32'b100, 3, vec);
        load(8'h55, 4'd9, 1'b1, d);
        check("t5_bad_load_detect", {31'd0, d}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, d, e);
        check("t5_err_len9", {31'd0, e}, 32'd1);
        check("t5_still_detect", {31'd0, d}, 32'd1);

        // Boundary lengths: len 1 (upper pattern bits ignored) and len 8
        ovl_req = 1'b0;
        load(8'hFE, 4'd1, 1'b0, d);
        stream(32'b0100, 4, vec);
        check("len1_vec", vec, 32'b1011);
        load(8'hA5, 4'd8, 1'b0, d);
        stream(32'hA5A5, 16, vec);
        check("len8_vec", vec, 32'h0101);

        // Reset mid-sequence loses the partial window
        do_reset();
        ovl_req = 1'b1;
        stream(32'b100, 3, vec);
        do_reset();
        stream(32'b1001, 4, vec);
        check("t6_after_rst_vec", vec, 32'b0001);

        // Counter saturation with CNT_W=2
        do_reset();
        stream(32'b1001001001001001, 16, vec);
        check("t6_sat_vec", vec, 32'b0001001001001001);
        idle(e);
        check("t6_sat_count", {30'd0, bus.match_count}, 32'(3 * CNT_ON));
        idle(e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
